// File: rtl/mem_access.sv
// rtl/mem_access.sv - memory-access pipeline stage: loads/stores over req/gnt/rvalid, single write-back record
module mem_access #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_in,
  output logic        ready_out,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [1:0]  mem_size,
  input  logic        load_unsigned,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  input  logic [4:0]  rd,
  input  logic        reg_we_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_wstrb,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        misalign,
  output logic        bus_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;

  // Fields of the accepted instruction kept for the response phase
  logic        op_load_q, op_load_d;
  logic        unsigned_q, unsigned_d;
  logic [1:0]  size_q, size_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic [4:0]  rd_q, rd_d;
  logic        reg_we_q, reg_we_d;

  logic        dmem_req_q, dmem_req_d;
  logic        dmem_we_q, dmem_we_d;
  logic [31:0] dmem_addr_q, dmem_addr_d;
  logic [3:0]  dmem_wstrb_q, dmem_wstrb_d;
  logic [31:0] dmem_wdata_q, dmem_wdata_d;
  logic        wb_valid_q, wb_valid_d;
  logic        wb_we_q, wb_we_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        misalign_q, misalign_d;
  logic        bus_err_q, bus_err_d;

  logic        accept;
  logic        is_mem;
  logic        bad_access;
  logic [3:0]  st_strb;
  logic [31:0] st_data;
  logic [31:0] rshift;
  logic [31:0] load_ext;

  assign ready_out = (state_q == S_IDLE);
  assign accept    = valid_in && ready_out;
  assign is_mem    = is_load || is_store;

  always_comb begin
    bad_access = 1'b0;
    st_strb    = 4'b0000;
    st_data    = store_data;
    case (mem_size)
      2'b00: begin
        st_strb = 4'b0001 << alu_result[1:0];
        st_data = {4{store_data[7:0]}};
      end
      2'b01: begin
        bad_access = alu_result[0];
        st_strb    = alu_result[1] ? 4'b1100 : 4'b0011;
        st_data    = {2{store_data[15:0]}};
      end
      2'b10: begin
        bad_access = (alu_result[1:0] != 2'b00);
        st_strb    = 4'b1111;
      end
      default: bad_access = 1'b1;
    endcase
  end

  // Aligned halfwords sit at lane 0 or 2, so one shift covers byte and halfword selection
  assign rshift = dmem_rdata >> {addr_lo_q, 3'b000};

  always_comb begin
    case (size_q)
      2'b00:   load_ext = unsigned_q ? {24'b0, rshift[7:0]}  : {{24{rshift[7]}}, rshift[7:0]};
      2'b01:   load_ext = unsigned_q ? {16'b0, rshift[15:0]} : {{16{rshift[15]}}, rshift[15:0]};
      default: load_ext = dmem_rdata;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    op_load_d    = op_load_q;
    unsigned_d   = unsigned_q;
    size_d       = size_q;
    addr_lo_d    = addr_lo_q;
    rd_d         = rd_q;
    reg_we_d     = reg_we_q;
    dmem_req_d   = dmem_req_q;
    dmem_we_d    = dmem_we_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_wstrb_d = dmem_wstrb_q;
    dmem_wdata_d = dmem_wdata_q;
    wb_valid_d   = 1'b0;
    wb_we_d      = wb_we_q;
    wb_rd_d      = wb_rd_q;
    wb_data_d    = wb_data_q;
    misalign_d   = 1'b0;
    bus_err_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_load_d  = is_load;
          unsigned_d = load_unsigned;
          size_d     = mem_size;
          addr_lo_d  = alu_result[1:0];
          rd_d       = rd;
          reg_we_d   = reg_we_in;
          if (!is_mem) begin
            wb_valid_d = 1'b1;
            wb_we_d    = reg_we_in;
            wb_rd_d    = rd;
            wb_data_d  = alu_result;
          end else if (bad_access) begin
            misalign_d = 1'b1;
            wb_valid_d = 1'b1;
            wb_we_d    = 1'b0;
            wb_rd_d    = rd;
          end else begin
            state_d      = S_REQ;
            dmem_req_d   = 1'b1;
            dmem_we_d    = !is_load;
            dmem_addr_d  = {alu_result[31:2], 2'b00};
            dmem_wstrb_d = is_load ? 4'b0000 : st_strb;
            dmem_wdata_d = st_data;
          end
        end
      end
      S_REQ: begin
        if (dmem_gnt) begin
          dmem_req_d   = 1'b0;
          dmem_we_d    = 1'b0;
          dmem_wstrb_d = 4'b0000;
          if (op_load_q) begin
            state_d = S_RESP;
            cnt_d   = 8'd0;
          end else begin
            state_d    = S_IDLE;
            wb_valid_d = 1'b1;
            wb_we_d    = 1'b0;
            wb_rd_d    = rd_q;
          end
        end
      end
      S_RESP: begin
        if (dmem_rvalid) begin
          state_d    = S_IDLE;
          wb_valid_d = 1'b1;
          wb_we_d    = reg_we_q;
          wb_rd_d    = rd_q;
          wb_data_d  = load_ext;
        end else if (cnt_q == TMO_LAST) begin
          state_d    = S_IDLE;
          bus_err_d  = 1'b1;
          wb_valid_d = 1'b1;
          wb_we_d    = 1'b0;
          wb_rd_d    = rd_q;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= 8'd0;
      op_load_q    <= 1'b0;
      unsigned_q   <= 1'b0;
      size_q       <= 2'b00;
      addr_lo_q    <= 2'b00;
      rd_q         <= 5'd0;
      reg_we_q     <= 1'b0;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= 32'd0;
      dmem_wstrb_q <= 4'b0000;
      dmem_wdata_q <= 32'd0;
      wb_valid_q   <= 1'b0;
      wb_we_q      <= 1'b0;
      wb_rd_q      <= 5'd0;
      wb_data_q    <= 32'd0;
      misalign_q   <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      op_load_q    <= op_load_d;
      unsigned_q   <= unsigned_d;
      size_q       <= size_d;
      addr_lo_q    <= addr_lo_d;
      rd_q         <= rd_d;
      reg_we_q     <= reg_we_d;
      dmem_req_q   <= dmem_req_d;
      dmem_we_q    <= dmem_we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wstrb_q <= dmem_wstrb_d;
      dmem_wdata_q <= dmem_wdata_d;
      wb_valid_q   <= wb_valid_d;
      wb_we_q      <= wb_we_d;
      wb_rd_q      <= wb_rd_d;
      wb_data_q    <= wb_data_d;
      misalign_q   <= misalign_d;
      bus_err_q    <= bus_err_d;
    end
  end

  assign dmem_req   = dmem_req_q;
  assign dmem_we    = dmem_we_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_wstrb = dmem_wstrb_q;
  assign dmem_wdata = dmem_wdata_q;
  assign wb_valid   = wb_valid_q;
  assign wb_we      = wb_we_q;
  assign wb_rd      = wb_rd_q;
  assign wb_data    = wb_data_q;
  assign misalign   = misalign_q;
  assign bus_err    = bus_err_q;

endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - directed self-checking bench for mem_access
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_in;
  logic        ready_out;
  logic        is_load;
  logic        is_store;
  logic [1:0]  mem_size;
  logic        load_unsigned;
  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic [4:0]  rd;
  logic        reg_we_in;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_wstrb;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        wb_valid;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        misalign;
  logic        bus_err;

  int n_checks = 0;
  int n_pass   = 0;

  mem_access #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .ready_out(ready_out),
    .is_load(is_load), .is_store(is_store), .mem_size(mem_size),
    .load_unsigned(load_unsigned), .alu_result(alu_result), .store_data(store_data),
    .rd(rd), .reg_we_in(reg_we_in), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wstrb(dmem_wstrb), .dmem_wdata(dmem_wdata),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .misalign(misalign), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Advance one edge; outputs are then sampled 1ns after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic ld, input logic st, input logic [1:0] sz,
                          input logic uns, input logic [31:0] a, input logic [31:0] d,
                          input logic [4:0] r, input logic we);
    valid_in = 1'b1; is_load = ld; is_store = st; mem_size = sz;
    load_unsigned = uns; alu_result = a; store_data = d; rd = r; reg_we_in = we;
    step();
    valid_in = 1'b0; is_load = 1'b0; is_store = 1'b0;
  endtask

  // Load with immediate gnt and rvalid on the first RESP cycle
  task automatic do_load(input string tag, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] rdata, input logic [31:0] exp);
    drive_op(1'b1, 1'b0, sz, uns, a, 32'h0, 5'd7, 1'b1);
    check({tag, "_req"}, 32'(dmem_req), 32'd1);
    check({tag, "_addr"}, dmem_addr, {a[31:2], 2'b00});
    check({tag, "_wstrb"}, 32'(dmem_wstrb), 32'd0);
    dmem_gnt = 1'b1;
    step();
    dmem_gnt = 1'b0;
    check({tag, "_resp_ready"}, 32'(ready_out), 32'd0);
    dmem_rvalid = 1'b1; dmem_rdata = rdata;
    step();
    dmem_rvalid = 1'b0;
    check({tag, "_wbv"}, 32'(wb_valid), 32'd1);
    check({tag, "_wbwe"}, 32'(wb_we), 32'd1);
    check({tag, "_wbrd"}, 32'(wb_rd), 32'd7);
    check({tag, "_data"}, wb_data, exp);
  endtask

  initial begin
    rst_n = 1'b0; valid_in = 1'b0; is_load = 1'b0; is_store = 1'b0; mem_size = 2'b00;
    load_unsigned = 1'b0; alu_result = 32'h0; store_data = 32'h0; rd = 5'd0;
    reg_we_in = 1'b0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
    step();
    step();
    check("rst_ready", 32'(ready_out), 32'd1);
    check("rst_req", 32'(dmem_req), 32'd0);
    check("rst_wbv", 32'(wb_valid), 32'd0);
    check("rst_addr", dmem_addr, 32'h0);
    check("rst_wbdata", wb_data, 32'h0);
    check("rst_flags", {30'd0, misalign, bus_err}, 32'd0);
    rst_n = 1'b1;
    step();

    // Pass-through
    drive_op(1'b0, 1'b0, 2'b10, 1'b0, 32'h1234_5678, 32'h0, 5'd5, 1'b1);
    check("pt_wbv", 32'(wb_valid), 32'd1);
    check("pt_data", wb_data, 32'h1234_5678);
    check("pt_rd", 32'(wb_rd), 32'd5);
    check("pt_we", 32'(wb_we), 32'd1);
    check("pt_noreq", 32'(dmem_req), 32'd0);
    step();
    check("pt_pulse", 32'(wb_valid), 32'd0);

    // Store byte at 0x103, gnt withheld two cycles
    drive_op(1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_0103, 32'hAABB_CCDD, 5'd1, 1'b0);
    check("sb_req1", 32'(dmem_req), 32'd1);
    check("sb_addr", dmem_addr, 32'h0000_0100);
    check("sb_wstrb", 32'(dmem_wstrb), 32'h8);
    check("sb_wdata", dmem_wdata, 32'hDDDD_DDDD);
    check("sb_we", 32'(dmem_we), 32'd1);
    check("sb_ready", 32'(ready_out), 32'd0);
    step();
    check("sb_req2", 32'(dmem_req), 32'd1);
    step();
    check("sb_req3", 32'(dmem_req), 32'd1);
    check("sb_addr_hold", dmem_addr, 32'h0000_0100);
    dmem_gnt = 1'b1;
    step();
    dmem_gnt = 1'b0;
    check("sb_req_drop", 32'(dmem_req), 32'd0);
    check("sb_wbv", 32'(wb_valid), 32'd1);
    check("sb_wbwe", 32'(wb_we), 32'd0);
    check("sb_ready_back", 32'(ready_out), 32'd1);

    // Halfword store at 0x102 with gnt high before the request exists
    dmem_gnt = 1'b1;
    drive_op(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0102, 32'hAABB_CCDD, 5'd1, 1'b0);
    check("sh_req", 32'(dmem_req), 32'd1);
    check("sh_wstrb", 32'(dmem_wstrb), 32'hC);
    check("sh_wdata", dmem_wdata, 32'hCCDD_CCDD);
    step();
    dmem_gnt = 1'b0;
    check("sh_wbv", 32'(wb_valid), 32'd1);

    // Word store
    dmem_gnt = 1'b1;
    drive_op(1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0204, 32'h1122_3344, 5'd1, 1'b0);
    check("sw_wstrb", 32'(dmem_wstrb), 32'hF);
    check("sw_wdata", dmem_wdata, 32'h1122_3344);
    step();
    dmem_gnt = 1'b0;

    // Loads
    do_load("lh_s", 2'b01, 1'b0, 32'h0000_0202, 32'h8001_0000, 32'hFFFF_8001);
    do_load("lh_u", 2'b01, 1'b1, 32'h0000_0202, 32'h8001_0000, 32'h0000_8001);
    do_load("lb_s", 2'b00, 1'b0, 32'h0000_0001, 32'h0000_8000, 32'hFFFF_FF80);
    do_load("lb_u", 2'b00, 1'b1, 32'h0000_0003, 32'hF200_0000, 32'h0000_00F2);
    do_load("lw", 2'b10, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

    // Misaligned word load and illegal size
    drive_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0301, 32'h0, 5'd3, 1'b1);
    check("mis_flag", 32'(misalign), 32'd1);
    check("mis_wbv", 32'(wb_valid), 32'd1);
    check("mis_wbwe", 32'(wb_we), 32'd0);
    check("mis_noreq", 32'(dmem_req), 32'd0);
    check("mis_ready", 32'(ready_out), 32'd1);
    step();
    check("mis_pulse", 32'(misalign), 32'd0);
    drive_op(1'b0, 1'b1, 2'b11, 1'b0, 32'h0000_0400, 32'h0, 5'd3, 1'b0);
    check("ill_flag", 32'(misalign), 32'd1);
    check("ill_noreq", 32'(dmem_req), 32'd0);

    // Timeout: four RESP cycles without rvalid
    drive_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0040, 32'h0, 5'd9, 1'b1);
    dmem_gnt = 1'b1;
    step();
    dmem_gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("to_wait", {30'd0, wb_valid, bus_err}, 32'd0);
    end
    step();
    check("to_berr", 32'(bus_err), 32'd1);
    check("to_wbv", 32'(wb_valid), 32'd1);
    check("to_wbwe", 32'(wb_we), 32'd0);
    check("to_ready", 32'(ready_out), 32'd1);

    // rvalid on the fourth RESP cycle beats the timeout
    drive_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0040, 32'h0, 5'd9, 1'b1);
    dmem_gnt = 1'b1;
    step();
    dmem_gnt = 1'b0;
    for (int i = 0; i < 3; i++) step();
    dmem_rvalid = 1'b1; dmem_rdata = 32'h0BAD_F00D;
    step();
    dmem_rvalid = 1'b0;
    check("late_berr", 32'(bus_err), 32'd0);
    check("late_wbv", 32'(wb_valid), 32'd1);
    check("late_wbwe", 32'(wb_we), 32'd1);
    check("late_data", wb_data, 32'h0BAD_F00D);

    // Reset while in RESP, then a stray rvalid
    drive_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0080, 32'h0, 5'd4, 1'b1);
    dmem_gnt = 1'b1;
    step();
    dmem_gnt = 1'b0;
    check("mr_in_resp", 32'(ready_out), 32'd0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("mr_req", 32'(dmem_req), 32'd0);
    check("mr_ready", 32'(ready_out), 32'd1);
    dmem_rvalid = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
    step();
    dmem_rvalid = 1'b0;
    check("mr_stray", 32'(wb_valid), 32'd0);
    step();
    check("mr_stray2", {30'd0, wb_valid, bus_err}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
